// File: rtl/cva6_clic_irq_stage.sv
// rtl/cva6_clic_irq_stage.sv - CLIC interrupt holding/eligibility stage in front of the CVA6 controller
// Optional accepted-interrupt counter: define CVA6_CLIC_IRQ_TAKEN_CNT_EN.
module cva6_clic_irq_stage #(
    parameter int unsigned NumSrc     = 256,
    parameter int unsigned IdWidth    = $clog2(NumSrc),
    parameter int unsigned LevelWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_valid_i,
    input  logic [IdWidth-1:0]    irq_id_i,
    input  logic [LevelWidth-1:0] irq_level_i,
    input  logic [1:0]            irq_priv_i,
    input  logic                  irq_shv_i,
    output logic                  irq_ready_o,
    input  logic                  kill_req_i,
    output logic                  kill_ack_o,
    input  logic                  irq_en_i,
    input  logic [1:0]            priv_lvl_i,
    input  logic [LevelWidth-1:0] mil_i,
    input  logic [LevelWidth-1:0] mintthresh_i,
    output logic                  core_irq_valid_o,
    output logic [IdWidth-1:0]    core_irq_id_o,
    output logic [LevelWidth-1:0] core_irq_level_o,
    output logic [1:0]            core_irq_priv_o,
    output logic                  core_irq_shv_o,
    input  logic                  core_irq_ready_i,
    output logic [31:0]           taken_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    state_e                r_state;
    logic                  r_valid;
    logic [IdWidth-1:0]    r_id;
    logic [LevelWidth-1:0] r_level;
    logic [1:0]            r_priv;
    logic                  r_shv;

    logic [LevelWidth-1:0] w_ceiling;
    logic                  w_elig_new;
    logic                  w_elig_held;
    logic                  w_accept;

    // An interrupt at the current privilege must beat both the active level and the threshold.
    assign w_ceiling   = (mil_i > mintthresh_i) ? mil_i : mintthresh_i;
    assign w_elig_new  = irq_en_i && ((irq_priv_i > priv_lvl_i) ||
                         ((irq_priv_i == priv_lvl_i) && (irq_level_i > w_ceiling)));
    assign w_elig_held = irq_en_i && ((r_priv > priv_lvl_i) ||
                         ((r_priv == priv_lvl_i) && (r_level > w_ceiling)));

    // Handshake outputs are suppressed during reset so a reset never looks like a completion.
    assign w_accept    = !rst_i && (r_state == ST_HOLD) && r_valid && core_irq_ready_i;
    assign irq_ready_o = w_accept;
    assign kill_ack_o  = !rst_i && (((r_state == ST_IDLE) && kill_req_i) ||
                                    (w_accept && kill_req_i) ||
                                    (r_state == ST_KILL));

    assign core_irq_valid_o = r_valid;
    assign core_irq_id_o    = r_id;
    assign core_irq_level_o = r_level;
    assign core_irq_priv_o  = r_priv;
    assign core_irq_shv_o   = r_shv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_level <= '0;
            r_priv  <= '0;
            r_shv   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (irq_valid_i && !kill_req_i) begin
                        r_id    <= irq_id_i;
                        r_level <= irq_level_i;
                        r_priv  <= irq_priv_i;
                        r_shv   <= irq_shv_i;
                        r_valid <= w_elig_new;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (kill_req_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_KILL;
                    end else begin
                        r_valid <= w_elig_held;
                    end
                end
                ST_KILL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CVA6_CLIC_IRQ_TAKEN_CNT_EN
    logic [31:0] r_taken_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_taken_cnt <= '0;
        end else if (w_accept) begin
            r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign taken_cnt_o = r_taken_cnt;
`else
    assign taken_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cva6_clic_irq_stage.sv
// tb/tb_cva6_clic_irq_stage.sv - self-checking bench for cva6_clic_irq_stage
module tb_cva6_clic_irq_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        irq_valid_i;
    logic [7:0]  irq_id_i;
    logic [7:0]  irq_level_i;
    logic [1:0]  irq_priv_i;
    logic        irq_shv_i;
    logic        irq_ready_o;
    logic        kill_req_i;
    logic        kill_ack_o;
    logic        irq_en_i;
    logic [1:0]  priv_lvl_i;
    logic [7:0]  mil_i;
    logic [7:0]  mintthresh_i;
    logic        core_irq_valid_o;
    logic [7:0]  core_irq_id_o;
    logic [7:0]  core_irq_level_o;
    logic [1:0]  core_irq_priv_o;
    logic        core_irq_shv_o;
    logic        core_irq_ready_i;
    logic [31:0] taken_cnt_o;

    always #5 clk_i = ~clk_i;

`ifdef CVA6_CLIC_IRQ_TAKEN_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    cva6_clic_irq_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .irq_valid_i      (irq_valid_i),
        .irq_id_i         (irq_id_i),
        .irq_level_i      (irq_level_i),
        .irq_priv_i       (irq_priv_i),
        .irq_shv_i        (irq_shv_i),
        .irq_ready_o      (irq_ready_o),
        .kill_req_i       (kill_req_i),
        .kill_ack_o       (kill_ack_o),
        .irq_en_i         (irq_en_i),
        .priv_lvl_i       (priv_lvl_i),
        .mil_i            (mil_i),
        .mintthresh_i     (mintthresh_i),
        .core_irq_valid_o (core_irq_valid_o),
        .core_irq_id_o    (core_irq_id_o),
        .core_irq_level_o (core_irq_level_o),
        .core_irq_priv_o  (core_irq_priv_o),
        .core_irq_shv_o   (core_irq_shv_o),
        .core_irq_ready_i (core_irq_ready_i),
        .taken_cnt_o      (taken_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a pending interrupt slot, a withdraw-ack owed flag, and a taken count.
    bit        m_pending;
    bit        m_ack_owed;
    bit        m_present;
    bit [7:0]  m_id, m_lvl;
    bit [1:0]  m_priv;
    bit        m_shv;
    bit [31:0] m_taken;

    function automatic bit eligible(int p, int l);
        int ceiling;
        ceiling = (int'(mil_i) > int'(mintthresh_i)) ? int'(mil_i) : int'(mintthresh_i);
        return irq_en_i && ((p > int'(priv_lvl_i)) || (p == int'(priv_lvl_i) && l > ceiling));
    endfunction

    function automatic bit taken_now();
        return !rst_i && m_pending && m_present && core_irq_ready_i;
    endfunction

    task automatic compare();
        bit exp_ack;
        exp_ack = !rst_i && (m_ack_owed || (taken_now() && kill_req_i) ||
                             (!m_pending && kill_req_i));
        check("core_valid", core_irq_valid_o, m_present);
        check("core_id",    core_irq_id_o,    m_id);
        check("core_level", core_irq_level_o, m_lvl);
        check("core_priv",  core_irq_priv_o,  m_priv);
        check("core_shv",   core_irq_shv_o,   m_shv);
        check("irq_ready",  irq_ready_o,      taken_now());
        check("kill_ack",   kill_ack_o,       exp_ack);
        check("taken_cnt",  taken_cnt_o,      m_taken);
    endtask

    task automatic model_step();
        if (rst_i) begin
            m_pending = 0; m_ack_owed = 0; m_present = 0;
            m_id = 0; m_lvl = 0; m_priv = 0; m_shv = 0; m_taken = 0;
        end else if (m_ack_owed) begin
            m_ack_owed = 0;
        end else if (!m_pending) begin
            if (irq_valid_i && !kill_req_i) begin
                m_pending = 1;
                m_id = irq_id_i; m_lvl = irq_level_i; m_priv = irq_priv_i; m_shv = irq_shv_i;
                m_present = eligible(int'(irq_priv_i), int'(irq_level_i));
            end
        end else if (taken_now()) begin
            m_pending = 0; m_present = 0;
            if (CntOn) m_taken = m_taken + 1;
        end else if (kill_req_i) begin
            m_pending = 0; m_present = 0; m_ack_owed = 1;
        end else begin
            m_present = eligible(int'(m_priv), int'(m_lvl));
        end
    endtask

    task automatic half();
        @(negedge clk_i);
        compare();
    endtask

    task automatic edge_step();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic cycle();
        half();
        edge_step();
    endtask

    task automatic quiet_inputs();
        irq_valid_i = 0; irq_id_i = 0; irq_level_i = 0; irq_priv_i = 0; irq_shv_i = 0;
        kill_req_i = 0; core_irq_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        quiet_inputs();
        edge_step();
        rst_i = 0;
    endtask

    task automatic request(input logic [7:0] id, input logic [7:0] lvl,
                           input logic [1:0] p, input logic shv);
        irq_valid_i = 1; irq_id_i = id; irq_level_i = lvl; irq_priv_i = p; irq_shv_i = shv;
    endtask

    initial begin
        rst_i = 1; irq_en_i = 1; priv_lvl_i = 2'd3; mil_i = 0; mintthresh_i = 0;
        quiet_inputs();
        edge_step();
        edge_step();
        rst_i = 0;

        // Basic accept: id 17 at cycle 0, core takes it in cycle 3.
        check("reset_valid", core_irq_valid_o, 1'b0);
        check("reset_cnt",   taken_cnt_o,      32'd0);
        request(8'd17, 8'h80, 2'd3, 1'b1);
        cycle();
        irq_valid_i = 0;
        check("basic_valid_c1", core_irq_valid_o, 1'b1);
        check("basic_id_c1",    core_irq_id_o,    32'd17);
        cycle();
        cycle();
        core_irq_ready_i = 1;
        half();
        check("basic_ready_c3", irq_ready_o, 1'b1);
        edge_step();
        core_irq_ready_i = 0;
        half();
        check("basic_valid_c4", core_irq_valid_o, 1'b0);
        check("basic_ready_c4", irq_ready_o,      1'b0);
        check("basic_cnt",      taken_cnt_o,      CntOn ? 32'd1 : 32'd0);
        edge_step();

        // Threshold gating: level equal to threshold is not eligible; lowering it opens the gate.
        do_reset();
        mintthresh_i = 8'h40;
        request(8'd5, 8'h40, 2'd3, 1'b0);
        cycle();
        irq_valid_i = 0;
        for (int c = 1; c <= 4; c++) cycle();
        mintthresh_i = 8'h3F;
        half();
        check("thr_gated_c5", core_irq_valid_o, 1'b0);
        edge_step();
        half();
        check("thr_open_c6",  core_irq_valid_o, 1'b1);
        check("thr_level_c6", core_irq_level_o, 32'h40);
        edge_step();

        // Privilege bypass: M-mode interrupt while in S ignores the threshold, unless disabled.
        do_reset();
        priv_lvl_i = 2'd1; mintthresh_i = 8'hFF;
        request(8'd9, 8'h01, 2'd3, 1'b0);
        cycle();
        irq_valid_i = 0;
        check("bypass_valid", core_irq_valid_o, 1'b1);
        do_reset();
        irq_en_i = 0;
        request(8'd9, 8'h01, 2'd3, 1'b0);
        cycle();
        irq_valid_i = 0;
        cycle();
        check("bypass_disabled", core_irq_valid_o, 1'b0);
        irq_en_i = 1; priv_lvl_i = 2'd3; mintthresh_i = 0;

        // Kill in HOLD, then a fresh request with id 42.
        do_reset();
        request(8'd3, 8'h10, 2'd3, 1'b0);
        cycle();
        irq_valid_i = 0;
        for (int c = 1; c <= 3; c++) cycle();
        kill_req_i = 1;
        cycle();
        kill_req_i = 0;
        half();
        check("kill_valid_c5", core_irq_valid_o, 1'b0);
        check("kill_ack_c5",   kill_ack_o,       1'b1);
        edge_step();
        request(8'd42, 8'h20, 2'd3, 1'b0);
        cycle();
        irq_valid_i = 0;
        check("kill_next_id",    core_irq_id_o,    32'd42);
        check("kill_next_valid", core_irq_valid_o, 1'b1);

        // Simultaneous kill and accept: accept wins, no withdraw state afterwards.
        core_irq_ready_i = 1; kill_req_i = 1;
        half();
        check("sim_ready", irq_ready_o, 1'b1);
        check("sim_ack",   kill_ack_o,  1'b1);
        edge_step();
        core_irq_ready_i = 0; kill_req_i = 0;
        half();
        check("sim_no_kill_state", kill_ack_o, 1'b0);
        edge_step();

        // Reset while valid: no ready pulse, everything cleared.
        request(8'd77, 8'hF0, 2'd3, 1'b1);
        cycle();
        irq_valid_i = 0;
        check("rst_pre_valid", core_irq_valid_o, 1'b1);
        rst_i = 1; core_irq_ready_i = 1;
        half();
        check("rst_no_ready", irq_ready_o, 1'b0);
        edge_step();
        rst_i = 0; core_irq_ready_i = 0;
        check("rst_valid", core_irq_valid_o, 1'b0);
        check("rst_id",    core_irq_id_o,    32'd0);
        check("rst_cnt",   taken_cnt_o,      32'd0);

        // Randomized traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            rst_i            = ($urandom_range(0, 99) < 2);
            irq_valid_i      = ($urandom_range(0, 99) < 50);
            irq_id_i         = 8'($urandom);
            irq_level_i      = 8'($urandom);
            irq_shv_i        = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       irq_priv_i = 2'd0;
                1:       irq_priv_i = 2'd1;
                default: irq_priv_i = 2'd3;
            endcase
            kill_req_i       = ($urandom_range(0, 99) < 10);
            core_irq_ready_i = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 15) irq_en_i = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 15) begin
                case ($urandom_range(0, 2))
                    0:       priv_lvl_i = 2'd0;
                    1:       priv_lvl_i = 2'd1;
                    default: priv_lvl_i = 2'd3;
                endcase
            end
            if ($urandom_range(0, 99) < 20) mil_i = 8'($urandom);
            if ($urandom_range(0, 99) < 20) mintthresh_i = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_clic_irq_stage.md
# cva6_clic_irq_stage

Holding and eligibility stage between the CLIC arbiter and the CVA6 controller's interrupt input in CLIC-enabled (SCLIC) configurations with 256 interrupt sources. It captures the arbiter's selected interrupt (id, level, privilege, SHV) and qualifies it against live `mintstatus.mil`, `mintthresh` and the current privilege level. It then presents it to the core with a valid/ready handshake. It also services the arbiter's kill/withdraw handshake.

## Interface
- `NumSrc`, 256: number of CLIC interrupt sources.
- `IdWidth`, $clog2(NumSrc) = 8: interrupt id width.
- `LevelWidth`, 8: interrupt level width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `irq_valid_i` in 1: arbiter request valid.
- `irq_id_i` in IdWidth: requested id.
- `irq_level_i` in LevelWidth: requested level.
- `irq_priv_i` in 2: target privilege (0 = U, 1 = S, 3 = M).
- `irq_shv_i` in 1: selective hardware vectoring.
- `irq_ready_o` in… out 1: request consumed by the core; a one-cycle pulse.
- `kill_req_i` in 1: arbiter withdraws the current request.
- `kill_ack_o` out 1: withdrawal complete.
- `irq_en_i` in 1: effective global interrupt enable for the target privilege.
- `priv_lvl_i` in 2: current hart privilege.
- `mil_i` in LevelWidth: `mintstatus` level of the current privilege.
- `mintthresh_i` in LevelWidth: threshold of the current privilege.
- `core_irq_valid_o` out 1: qualified request to the core.
- `core_irq_id_o`, `core_irq_level_o`, `core_irq_priv_o`, `core_irq_shv_o` out IdWidth/LevelWidth/2/1: held payload.
- `core_irq_ready_i` in 1: core takes the trap.
- `taken_cnt_o` out 32: accepted-interrupt count (see Configuration).

## Operation
- FSM states:
  - IDLE: nothing held.
  - HOLD: payload held.
  - KILL: withdrawal acknowledge.
- `elig(p, l)` = `irq_en_i && ((p > priv_lvl_i) || (p == priv_lvl_i && l > max(mil_i, mintthresh_i)))`.
  - Comparisons are unsigned.
  - `p < priv_lvl_i` is never eligible.
- IDLE:
  - If `irq_valid_i && !kill_req_i`: capture the payload, set `valid_q <= elig(irq_priv_i, irq_level_i)`, and go to HOLD.
  - If `kill_req_i` in IDLE: `kill_ack_o = 1` combinationally the same cycle; no capture.
- HOLD, evaluated in priority order:
  - Accept: `accept = core_irq_valid_o && core_irq_ready_i`.
    - `irq_ready_o = 1` the same cycle.
    - `kill_ack_o = kill_req_i` the same cycle (accept wins over a simultaneous kill).
    - Next state is IDLE; `valid_q` clears.
  - Else if `kill_req_i`: clear `valid_q` and go to KILL.
  - Else: `valid_q <= elig(held priv, held level)` every cycle. Valid may drop and re-rise as CSRs change; the payload stays frozen.
- While in HOLD, `irq_valid_i` and the payload inputs are ignored. The arbiter must not change the payload without a kill.
- KILL: `kill_ack_o = 1` for exactly one cycle, then IDLE. A new request can be captured in the following IDLE cycle.
- `core_irq_valid_o = valid_q`. Payload outputs come from the held registers.

## Timing
- Reset values:
  - State IDLE.
  - `core_irq_valid_o` = 0.
  - All payload outputs 0.
  - `irq_ready_o` = 0, `kill_ack_o` = 0.
  - `taken_cnt_o` = 0.
- Reset mid-HOLD or mid-KILL: everything returns to reset values on the next edge; no `irq_ready_o` or `kill_ack_o` pulse is emitted.
- Capture latency: `irq_valid_i` sampled at edge N gives `core_irq_valid_o` in cycle N+1 (if eligible).
- Eligibility re-evaluation latency: a CSR change in cycle N is reflected on `core_irq_valid_o` in cycle N+1.
- After accept in cycle N: `core_irq_valid_o` = 0 in N+1, state IDLE. The earliest next capture is at edge N+1, giving a new valid in N+2.
- Kill in HOLD in cycle N: valid = 0 and `kill_ack_o` = 1 in N+1; IDLE in N+2.
- `irq_ready_o` and `kill_ack_o` are combinational from state and inputs. There is no combinational path from `irq_*` payload inputs to core outputs.

## Configuration
- `CVA6_CLIC_IRQ_TAKEN_CNT_EN` defined:
  - 32-bit counter increments by 1 on every accept and wraps 0xFFFF_FFFF → 0.
  - Reset to 0; driven on `taken_cnt_o`.
- Undefined: no counter; `taken_cnt_o` is tied to 0.

## Test plan
- Basic accept:
  - Stimulus: `priv_lvl_i` = M, `mil_i` = 0, `mintthresh_i` = 0; request id 17, level 0x80, priv M, shv 1 in cycle 0; `core_irq_ready_i` in cycle 3.
  - Response: valid = 1 with id 17 from cycle 1; `irq_ready_o` = 1 in cycle 3 only; valid = 0 in cycle 4; `taken_cnt_o` = 1.
- Threshold gating:
  - Stimulus: level 0x40, same priv, `mintthresh_i` = 0x40; lower the threshold to 0x3F in cycle 5.
  - Response: valid = 0 through cycle 5, valid = 1 in cycle 6; payload unchanged.
- Privilege bypass:
  - Stimulus: `irq_priv_i` = M, `priv_lvl_i` = S, `mintthresh_i` = 0xFF, `irq_en_i` = 1.
  - Response: valid = 1 next cycle. With `irq_en_i` = 0, valid stays 0.
- Kill in HOLD:
  - Stimulus: `kill_req_i` in cycle 4 of HOLD.
  - Response: valid = 0 and `kill_ack_o` = 1 in cycle 5; IDLE in cycle 6. A following request with id 42 is captured and presented with id 42.
- Simultaneous kill and accept:
  - Stimulus: `kill_req_i` and `core_irq_ready_i` both high while valid.
  - Response: `irq_ready_o` = 1 and `kill_ack_o` = 1 in the same cycle; no KILL state; counter increments once.
- Reset mid-HOLD:
  - Stimulus: assert `rst_i` while valid = 1.
  - Response: all outputs 0 next cycle; no `irq_ready_o`; counter = 0.
